// File: rtl/ringbuf_rd_if.sv
// Consumer-side valid/ready channel of ringbuf_rd.
//   o_data  : registered head entry of the output stage
//   o_valid : o_data holds a valid entry
//   i_ready : consumer accepts o_data this cycle
// master = ringbuf_rd (drives data/valid), slave = consumer (drives ready).
interface ringbuf_rd_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/ringbuf.sv
// Read-side controller for a status-less ringbuf.
// Mirrors the buffer occupancy from the write strobe, pops the head with a
// single-cycle o_re pulse and hands entries to a consumer through a 2-entry
// registered output stage (main + skid).
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_we           : copy of the ringbuf write strobe
//   i_rb_data      : ringbuf head entry (combinational)
//   o_re           : ringbuf pop strobe (combinational from state and i_ready)
//   o_count        : entries held in ringbuf, excluding the output stage
//   o_full         : o_count == SIZE
//   o_ovf          : sticky overflow (write while full with no pop)
//   cons           : consumer valid/ready channel (o_data, o_valid, i_ready)
module ringbuf_rd #(
    parameter int unsigned  WIDTH = 32,
    parameter int unsigned  SIZE  = 8,
    localparam int unsigned CW    = $clog2(SIZE) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_rb_data,
    output logic             o_re,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_ovf,
    ringbuf_rd_if.master     cons
);

    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;

    logic             re_c;
    logic             xfer_c;
    logic             acc_c;
    logic [1:0]       occ_after_c;

    // Next-state: occupancy mirror, pop decision and output-stage steering.
    always_comb begin
        xfer_c      = valid_q & cons.i_ready;
        // Pop only when the stage has room now or will free a slot this cycle.
        re_c        = (count_q != '0) & ((occ_q < 2'd2) | cons.i_ready);
        acc_c       = i_we & (~full_q | re_c);
        count_d     = count_q + CW'(acc_c) - CW'(re_c);
        full_d      = (count_d == CW'(SIZE));
        ovf_d       = ovf_q | (i_we & full_q & ~re_c);

        occ_after_c = occ_q - 2'(xfer_c);
        occ_d       = occ_after_c + 2'(re_c);
        valid_d     = (occ_d != 2'd0);

        main_d      = main_q;
        skid_d      = skid_q;
        if (xfer_c && (occ_q == 2'd2)) begin
            main_d = skid_q;
        end
        // Popped entry lands in main only if main is vacated by this cycle's transfer.
        if (re_c) begin
            if (occ_after_c == 2'd0) begin
                main_d = i_rb_data;
            end else begin
                skid_d = i_rb_data;
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            occ_q   <= 2'd0;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            occ_q   <= occ_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_re         = re_c;
    assign o_count      = count_q;
    assign o_full       = full_q;
    assign o_ovf        = ovf_q;
    assign cons.o_data  = main_q;
    assign cons.o_valid = valid_q;

endmodule

// File: tb/tb_ringbuf_rd.sv
// Self-checking bench for ringbuf_rd with a behavioural ringbuf and a
// scoreboard of accepted writes checked by a negedge monitor.
module tb_ringbuf_rd;
    localparam int unsigned W  = 4;
    localparam int unsigned SZ = 8;
    localparam int unsigned CW = $clog2(SZ) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          we    = 1'b0;
    logic          ready = 1'b0;
    logic [W-1:0]  wd    = '0;
    logic [W-1:0]  rb_data = '0;
    logic          re;
    logic [CW-1:0] count;
    logic          full;
    logic          ovf;
    logic          valid;
    logic [W-1:0]  data;

    int vectors = 0;
    int errors  = 0;
    int xfers   = 0;

    ringbuf_rd_if #(.WIDTH(W)) cons ();
    assign cons.i_ready = ready;
    assign valid        = cons.o_valid;
    assign data         = cons.o_data;

    ringbuf_rd #(.WIDTH(W), .SIZE(SZ)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_we     (we),
        .i_rb_data(rb_data),
        .o_re     (re),
        .o_count  (count),
        .o_full   (full),
        .o_ovf    (ovf),
        .cons     (cons)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural ringbuf: head visible combinationally, pop/push at the edge.
    logic [W-1:0] rb_q[$];
    logic         we_s = 1'b0;
    logic         re_s = 1'b0;
    logic [W-1:0] wd_s = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q.delete();
            rb_data <= '0;
        end else begin
            if (re_s && rb_q.size() != 0) rb_q.delete(0);
            if (we_s && rb_q.size() < SZ) rb_q.push_back(wd_s);
            rb_data <= (rb_q.size() != 0) ? rb_q[0] : '0;
        end
    end

    // Scoreboard: every accepted write must come out once, in order.
    logic [W-1:0] sb[$];
    logic         ovf_m  = 1'b0;
    logic         stall_p = 1'b0;
    logic [W-1:0] data_p = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            ovf_m   = 1'b0;
            stall_p = 1'b0;
            we_s    = 1'b0;
            re_s    = 1'b0;
        end else begin
            chk("count", 32'(count), 32'(rb_q.size()));
            chk("full", 32'(full), 32'(rb_q.size() == SZ));
            chk("ovf", 32'(ovf), 32'(ovf_m));
            if (rb_q.size() == 0) chk("re_when_empty", 32'(re), 32'd0);
            if (stall_p) begin
                chk("hold_valid", 32'(valid), 32'd1);
                chk("hold_data", 32'(data), 32'(data_p));
            end
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL spurious_out: got %0h with no entry expected (t=%0t)", data, $time);
                end else begin
                    chk("out_data", 32'(data), 32'(sb.pop_front()));
                    xfers++;
                end
            end
            stall_p = valid & ~ready;
            data_p  = data;
            if (we) begin
                if (rb_q.size() < SZ || re) sb.push_back(wd);
                else ovf_m = 1'b1;
            end
            we_s = we;
            re_s = re;
            wd_s = wd;
        end
    end

    initial begin
        int  x0;
        bit  done;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_re", 32'(re), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write, two edges to valid
        ready = 1'b1;
        we = 1'b1; wd = 4'hA;
        cyc();
        we = 1'b0;
        chk("t1_re", 32'(re), 32'd1);
        chk("t1_valid0", 32'(valid), 32'd0);
        cyc();
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_data", 32'(data), 32'hA);
        chk("t1_count", 32'(count), 32'd0);
        cyc();
        chk("t1_drop", 32'(valid), 32'd0);

        // Fill under backpressure, then overflow
        ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            we = 1'b1; wd = W'(i);
            cyc();
        end
        we = 1'b0;
        chk("t2_data", 32'(data), 32'd1);
        chk("t2_count", 32'(count), 32'd8);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_re", 32'(re), 32'd0);
        we = 1'b1; wd = 4'hB;
        cyc();
        we = 1'b0;
        chk("t2_ovf", 32'(ovf), 32'd1);
        chk("t2_count_hold", 32'(count), 32'd8);

        // Drain at full rate
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid", 32'(valid), 32'd1);
            chk("t3_data", 32'(data), 32'(i + 1));
            if (i == 1) chk("t3_full_clr", 32'(full), 32'd0);
            cyc();
        end
        chk("t3_empty", 32'(valid), 32'd0);
        chk("t3_count", 32'(count), 32'd0);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);

        // Back-to-back stream
        we = 1'b1; wd = 4'h1;
        cyc();
        chk("t4_lat", 32'(valid), 32'd0);
        for (int j = 2; j <= 6; j++) begin
            if (j <= 5) wd = W'(j);
            else we = 1'b0;
            cyc();
            chk("t4_valid", 32'(valid), 32'd1);
            chk("t4_data", 32'(data), 32'(j - 1));
        end
        cyc();
        chk("t4_end", 32'(valid), 32'd0);

        // Stream with a 2-cycle consumer stall
        x0 = xfers;
        for (int i = 1; i <= 6; i++) begin
            we = 1'b1; wd = W'(i);
            ready = !(i == 3 || i == 4);
            cyc();
        end
        we = 1'b0; ready = 1'b1;
        repeat (8) cyc();
        chk("t5_xfers", 32'(xfers - x0), 32'd6);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Async reset mid-stream
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            we = 1'b1; wd = W'(i);
            cyc();
        end
        we = 1'b0;
        chk("t6_pre_valid", 32'(valid), 32'd1);
        chk("t6_pre_count", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_data", 32'(data), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_full", 32'(full), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic: heavy backpressure then light
        for (int c = 0; c < 400; c++) begin
            we    = ($urandom_range(0, 99) < 55);
            wd    = W'($urandom);
            ready = ($urandom_range(0, 99) < ((c < 200) ? 30 : 75));
            cyc();
        end

        // Bounded drain
        we = 1'b0; ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            cyc();
            if (count == '0 && !valid) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: count %0d valid %0b after 40 cycles", count, valid);
        end
        cyc();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
